kb_cmd_ctrl: RTL and testbench

Host-to-keyboard command sequencer for the PS/2 keyboard path. It owns the shared PS/2 line between the receiver and a PS/2 transmitter. It issues keyboard reset (0xFF) and LED-set (0xED + data) commands, consumes the keyboard's protocol replies (ACK 0xFA, RESEND 0xFE, BAT 0xAA/0xFC), and forwards all other received bytes to the scan-code decoder. It sits between the PS/2 rx/tx PHYs and the keyboard decoder, and gates `rx_en` while transmitting.

---
 rtl/kb_cmd_ctrl_if.sv | 24 ++
 rtl/kb_cmd_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_kb_cmd_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kb_cmd_ctrl_if.sv
// PS/2 PHY-side signal bundle for the keyboard command sequencer.
// The master side is the sequencer; the slave side is the rx/tx PHYs
// plus the scan-code decoder.
interface kb_cmd_ctrl_if;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_wr;
  logic [7:0] tx_din;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       rx_en;
  logic       scan_tick_out;
  logic [7:0] scan_dout;

  modport master (
    input  tx_idle, tx_done_tick, rx_done_tick, rx_dout,
    output tx_wr, tx_din, rx_en, scan_tick_out, scan_dout
  );

  modport slave (
    output tx_idle, tx_done_tick, rx_done_tick, rx_dout,
    input  tx_wr, tx_din, rx_en, scan_tick_out, scan_dout
  );
endinterface

// File: rtl/kb_cmd_ctrl.sv
// Host-to-keyboard command sequencer. Sends keyboard reset (0xFF) and
// LED-set (0xED + data), consumes ACK/RESEND/BAT replies with retry and
// timeout handling, and forwards all other received bytes to the decoder.
module kb_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES     = 2_000_000,
  parameter int BAT_TIMEOUT_CYCLES = 60_000_000,
  parameter int MAX_RETRY          = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_req,
  input  logic               led_req,
  input  logic [2:0]         led_val,
  kb_cmd_ctrl_if.master      bus,
  output logic               busy,
  output logic               cmd_err,
  output logic               kb_ok
);

  localparam int TMO_LIMIT = (TIMEOUT_CYCLES > BAT_TIMEOUT_CYCLES) ?
                             TIMEOUT_CYCLES : BAT_TIMEOUT_CYCLES;
  localparam int TMO_W     = (TMO_LIMIT > 2) ? $clog2(TMO_LIMIT) : 1;
  localparam int RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] BAT_END = TMO_W'(BAT_TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_TX_WAIT_IDLE = 3'd1,
    ST_TX_STROBE    = 3'd2,
    ST_TX_WAIT_DONE = 3'd3,
    ST_ACK_WAIT     = 3'd4,
    ST_BAT_WAIT     = 3'd5
  } state_t;

  typedef enum logic {
    CMD_INIT = 1'b0,
    CMD_LED  = 1'b1
  } cmd_t;

  state_t            state_r, state_nx;
  cmd_t              cmd_r, cmd_nx;
  logic              byte_idx_r, byte_idx_nx;
  logic [2:0]        led_q_r, led_q_nx;
  logic [RTY_W-1:0]  retry_cnt_r, retry_nx;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic              cmd_err_r, err_nx;
  logic              kb_ok_r, ok_nx;
  logic              tmo_clr_s;
  logic              retry_s;
  logic              tmo_hit_s;
  logic              bat_hit_s;
  logic              rx_fa_s, rx_fe_s, rx_aa_s, rx_fc_s;
  logic              fwd_state_s;
  logic              wait_state_s;
  logic [7:0]        tx_byte_s;

  logic              tx_wr_r;
  logic [7:0]        tx_din_r;
  logic              rx_en_r;
  logic              scan_tick_r;
  logic [7:0]        scan_dout_r;
  logic              busy_r;

  // Decode reply bytes, timeout hits and per-state qualifiers.
  always_comb begin
    rx_fa_s      = bus.rx_done_tick && (bus.rx_dout == 8'hFA);
    rx_fe_s      = bus.rx_done_tick && (bus.rx_dout == 8'hFE);
    rx_aa_s      = bus.rx_done_tick && (bus.rx_dout == 8'hAA);
    rx_fc_s      = bus.rx_done_tick && (bus.rx_dout == 8'hFC);
    tmo_hit_s    = (tmo_cnt_r == TMO_END);
    bat_hit_s    = (tmo_cnt_r == BAT_END);
    fwd_state_s  = (state_r == ST_IDLE) || (state_r == ST_TX_WAIT_IDLE) ||
                   (state_r == ST_TX_STROBE);
    wait_state_s = (state_r == ST_TX_WAIT_IDLE) || (state_r == ST_TX_WAIT_DONE) ||
                   (state_r == ST_ACK_WAIT) || (state_r == ST_BAT_WAIT);
  end

  // Select the byte for the current command step.
  always_comb begin
    tx_byte_s = 8'h00;
    if (cmd_r == CMD_INIT) begin
      tx_byte_s = 8'hFF;
    end else if (byte_idx_r) begin
      tx_byte_s = {5'b00000, led_q_r};
    end else begin
      tx_byte_s = 8'hED;
    end
  end

  // Next-state and next-register logic for the command sequencer.
  always_comb begin
    state_nx    = state_r;
    cmd_nx      = cmd_r;
    byte_idx_nx = byte_idx_r;
    led_q_nx    = led_q_r;
    retry_nx    = retry_cnt_r;
    err_nx      = cmd_err_r;
    ok_nx       = kb_ok_r;
    retry_s     = 1'b0;
    tmo_clr_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (init_req) begin
          cmd_nx      = CMD_INIT;
          byte_idx_nx = 1'b0;
          retry_nx    = '0;
          err_nx      = 1'b0;
          ok_nx       = 1'b0;
          state_nx    = ST_TX_WAIT_IDLE;
        end else if (led_req) begin
          cmd_nx      = CMD_LED;
          byte_idx_nx = 1'b0;
          retry_nx    = '0;
          err_nx      = 1'b0;
          led_q_nx    = led_val;
          state_nx    = ST_TX_WAIT_IDLE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_TX_WAIT_IDLE: begin
        if (bus.tx_idle) begin
          state_nx = ST_TX_STROBE;
        end else if (tmo_hit_s) begin
          retry_s = 1'b1;
        end else begin
          state_nx = ST_TX_WAIT_IDLE;
        end
      end
      ST_TX_STROBE: begin
        state_nx = ST_TX_WAIT_DONE;
      end
      ST_TX_WAIT_DONE: begin
        if (bus.tx_done_tick) begin
          state_nx = ST_ACK_WAIT;
        end else if (tmo_hit_s) begin
          retry_s = 1'b1;
        end else begin
          state_nx = ST_TX_WAIT_DONE;
        end
      end
      ST_ACK_WAIT: begin
        if (rx_fa_s) begin
          if (cmd_r == CMD_INIT) begin
            state_nx = ST_BAT_WAIT;
          end else if (!byte_idx_r) begin
            byte_idx_nx = 1'b1;
            retry_nx    = '0;
            state_nx    = ST_TX_WAIT_IDLE;
          end else begin
            state_nx = ST_IDLE;
          end
        end else if (rx_fe_s || tmo_hit_s) begin
          // Replies win over a coinciding timeout; both lead to a resend.
          retry_s = 1'b1;
        end else begin
          state_nx = ST_ACK_WAIT;
        end
      end
      ST_BAT_WAIT: begin
        if (rx_aa_s) begin
          ok_nx    = 1'b1;
          state_nx = ST_IDLE;
        end else if (rx_fc_s || bat_hit_s) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_BAT_WAIT;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    if (retry_s) begin
      if (retry_cnt_r < RTY_MAX) begin
        retry_nx = retry_cnt_r + RTY_W'(1);
        state_nx = ST_TX_WAIT_IDLE;
      end else begin
        err_nx   = 1'b1;
        state_nx = ST_IDLE;
      end
    end else begin
      retry_nx = retry_nx;
    end

    // A resend re-enters TX_WAIT_IDLE, so it restarts the timer too.
    tmo_clr_s = (state_nx != state_r) || retry_s;
  end

  // State and command context registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cmd_r       <= CMD_INIT;
      byte_idx_r  <= 1'b0;
      led_q_r     <= 3'b000;
      retry_cnt_r <= '0;
      cmd_err_r   <= 1'b0;
      kb_ok_r     <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cmd_r       <= cmd_nx;
      byte_idx_r  <= byte_idx_nx;
      led_q_r     <= led_q_nx;
      retry_cnt_r <= retry_nx;
      cmd_err_r   <= err_nx;
      kb_ok_r     <= ok_nx;
    end
  end

  // Wait-state timer: restarts on every state entry, counts while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if (tmo_clr_s) begin
      tmo_cnt_r <= '0;
    end else if (wait_state_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  // Registered transmit strobe, transmit byte, receiver gate and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_r  <= 1'b0;
      tx_din_r <= 8'h00;
      rx_en_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      tx_wr_r  <= (state_nx == ST_TX_STROBE);
      tx_din_r <= (state_nx == ST_TX_STROBE) ? tx_byte_s : tx_din_r;
      rx_en_r  <= !((state_nx == ST_TX_STROBE) || (state_nx == ST_TX_WAIT_DONE));
      busy_r   <= (state_nx != ST_IDLE);
    end
  end

  // Forward non-protocol bytes received outside the reply-wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_tick_r <= 1'b0;
      scan_dout_r <= 8'h00;
    end else if (bus.rx_done_tick && fwd_state_s) begin
      scan_tick_r <= 1'b1;
      scan_dout_r <= bus.rx_dout;
    end else begin
      scan_tick_r <= 1'b0;
      scan_dout_r <= scan_dout_r;
    end
  end

  assign bus.tx_wr         = tx_wr_r;
  assign bus.tx_din        = tx_din_r;
  assign bus.rx_en         = rx_en_r;
  assign bus.scan_tick_out = scan_tick_r;
  assign bus.scan_dout     = scan_dout_r;
  assign busy              = busy_r;
  assign cmd_err           = cmd_err_r;
  assign kb_ok             = kb_ok_r;

endmodule

// File: tb/tb_kb_cmd_ctrl.sv
// Scoreboard bench for kb_cmd_ctrl: stimulus pushes expected tx bytes,
// forwarded bytes and end-of-command status; a monitor pops and compares.
module tb_kb_cmd_ctrl;

  localparam logic [1:0] K_TX   = 2'd0;
  localparam logic [1:0] K_SCAN = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       init_req;
  logic       led_req;
  logic [2:0] led_val;
  logic       busy;
  logic       cmd_err;
  logic       kb_ok;

  kb_cmd_ctrl_if bus ();

  kb_cmd_ctrl #(
    .TIMEOUT_CYCLES     (100),
    .BAT_TIMEOUT_CYCLES (300),
    .MAX_RETRY          (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .init_req (init_req),
    .led_req  (led_req),
    .led_val  (led_val),
    .bus      (bus),
    .busy     (busy),
    .cmd_err  (cmd_err),
    .kb_ok    (kb_ok)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   last_wr = -1;
  int   exp_gap = 0;
  logic prev_busy = 1'b0;
  logic phy_auto = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [7:0] data);
    exp_q.push_back('{kind: kind, data: data});
  endtask

  task automatic check_evt(input string name, input logic [1:0] kind, input logic [7:0] data);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL %s: unexpected output 0x%0h, nothing expected", name, data);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind !== kind) || (e.data !== data)) begin
        n_mis++;
        $display("FAIL %s: got kind %0d data 0x%0h expected kind %0d data 0x%0h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (bus.tx_wr) begin
          wr_cnt++;
          check_evt("tx_byte", K_TX, bus.tx_din);
          chk("rx_en_in_strobe", 32'(bus.rx_en), 32'd0);
          if ((exp_gap != 0) && (last_wr >= 0)) begin
            chk("retx_gap", 32'(cyc - last_wr), 32'(exp_gap));
          end
          last_wr = cyc;
        end
        if (bus.scan_tick_out) begin
          check_evt("scan_byte", K_SCAN, bus.scan_dout);
        end
        if (prev_busy && !busy) begin
          check_evt("done_status", K_DONE, {6'b000000, cmd_err, kb_ok});
        end
        prev_busy = busy;
      end
    end
  end

  // PHY model: answers each transmit strobe with tx_done_tick 3 cycles later.
  initial begin
    bus.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_wr && !reset && phy_auto) begin
        repeat (2) @(negedge clk);
        @(negedge clk);
        bus.tx_done_tick = 1'b1;
        done_cnt++;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
      end
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    bus.rx_dout      = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while ((done_cnt < target) && (k < 2000)) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) begin
      chk("tx_done_wait_timeout", 32'(done_cnt), 32'(target));
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      chk("busy_wait_timeout", 32'(busy), 32'd0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_req(input logic do_init, input logic do_led, input logic [2:0] val);
    @(negedge clk);
    init_req = do_init;
    led_req  = do_led;
    led_val  = val;
    @(negedge clk);
    init_req = 1'b0;
    led_req  = 1'b0;
  endtask

  initial begin
    int base;
    reset            = 1'b1;
    init_req         = 1'b0;
    led_req          = 1'b0;
    led_val          = 3'b000;
    bus.tx_idle      = 1'b1;
    bus.rx_done_tick = 1'b0;
    bus.rx_dout      = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx_wr", 32'(bus.tx_wr), 32'd0);
    chk("rst_tx_din", 32'(bus.tx_din), 32'h00);
    chk("rst_rx_en", 32'(bus.rx_en), 32'd1);
    chk("rst_scan_tick", 32'(bus.scan_tick_out), 32'd0);
    chk("rst_scan_dout", 32'(bus.scan_dout), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_kb_ok", 32'(kb_ok), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Scan bytes in IDLE are forwarded
    push(K_SCAN, 8'h1C); send_rx(8'h1C);
    push(K_SCAN, 8'hF0); send_rx(8'hF0);
    push(K_SCAN, 8'h1C); send_rx(8'h1C);
    repeat (3) @(negedge clk);

    // LED update 3'b101; a 0x1C in ACK_WAIT must be swallowed
    base = done_cnt;
    push(K_TX, 8'hED); push(K_TX, 8'h05); push(K_DONE, 8'h00);
    pulse_req(1'b0, 1'b1, 3'b101);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_done(base + 1);
    send_rx(8'h1C);
    send_rx(8'hFA);
    wait_done(base + 2);
    send_rx(8'hFA);
    wait_idle(500);

    // Keyboard reset, BAT pass; a stray byte in BAT_WAIT is swallowed
    base = done_cnt;
    push(K_TX, 8'hFF); push(K_DONE, 8'h01);
    pulse_req(1'b1, 1'b0, 3'b000);
    wait_done(base + 1);
    send_rx(8'hFA);
    send_rx(8'h12);
    send_rx(8'hAA);
    wait_idle(500);

    // Keyboard reset, BAT fail
    base = done_cnt;
    push(K_TX, 8'hFF); push(K_DONE, 8'h02);
    pulse_req(1'b1, 1'b0, 3'b000);
    wait_done(base + 1);
    send_rx(8'hFA);
    send_rx(8'hFC);
    wait_idle(500);

    // Three resends then ACK: four identical bytes, success
    base = done_cnt;
    for (int i = 0; i < 4; i++) push(K_TX, 8'hFF);
    push(K_DONE, 8'h01);
    pulse_req(1'b1, 1'b0, 3'b000);
    for (int i = 1; i <= 3; i++) begin
      wait_done(base + i);
      send_rx(8'hFE);
    end
    wait_done(base + 4);
    send_rx(8'hFA);
    send_rx(8'hAA);
    wait_idle(500);

    // Four resends on an LED command: error, kb_ok untouched
    base = done_cnt;
    for (int i = 0; i < 4; i++) push(K_TX, 8'hED);
    push(K_DONE, 8'h03);
    pulse_req(1'b0, 1'b1, 3'b011);
    for (int i = 1; i <= 4; i++) begin
      wait_done(base + i);
      send_rx(8'hFE);
    end
    wait_idle(500);

    // No ACK at all: retransmit every 100 ACK_WAIT cycles, error after 4th
    for (int i = 0; i < 4; i++) push(K_TX, 8'hFF);
    push(K_DONE, 8'h02);
    last_wr = -1;
    exp_gap = 105;
    pulse_req(1'b1, 1'b0, 3'b000);
    wait_idle(2000);
    exp_gap = 0;

    // Simultaneous requests: init wins; held off until tx_idle
    base = done_cnt;
    push(K_TX, 8'hFF); push(K_DONE, 8'h01);
    bus.tx_idle = 1'b0;
    pulse_req(1'b1, 1'b1, 3'b111);
    begin
      int w0;
      w0 = wr_cnt;
      repeat (10) @(negedge clk);
      chk("hold_while_tx_busy", 32'(wr_cnt), 32'(w0));
    end
    bus.tx_idle = 1'b1;
    wait_done(base + 1);
    send_rx(8'hFA);
    send_rx(8'hAA);
    wait_idle(500);

    // Asynchronous reset while waiting for tx_done
    phy_auto = 1'b0;
    base = wr_cnt;
    push(K_TX, 8'hED);
    pulse_req(1'b0, 1'b1, 3'b001);
    begin
      int k = 0;
      while ((wr_cnt == base) && (k < 100)) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (2) @(negedge clk);
    chk("rx_en_in_wait_done", 32'(bus.rx_en), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rx_en", 32'(bus.rx_en), 32'd1);
    chk("arst_tx_din", 32'(bus.tx_din), 32'h00);
    chk("arst_scan_dout", 32'(bus.scan_dout), 32'h00);
    chk("arst_kb_ok", 32'(kb_ok), 32'd0);
    chk("arst_cmd_err", 32'(cmd_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    phy_auto = 1'b1;
    repeat (30) @(negedge clk);
    chk("idle_after_reset", 32'(busy), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
